count_wrap_monitor: RTL and testbench



---
 rtl/count_pkg.sv | 22 ++
 rtl/count_step_classifier.sv | 46 ++++
 rtl/count_wrap_monitor.sv | 122 ++++++++++++
 tb/tb_count_wrap_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and defaults for the up/down counter and its wrap monitor.
// Holds the FSM state and transition-class enums used by RTL and scoreboard.
package count_pkg;

    localparam int COUNT_WIDTH = 4;
    localparam int COUNT_MAX   = 15;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRACK,
        ST_FAULT
    } mon_state_e;

    typedef enum logic [2:0] {
        TR_HOLD,
        TR_STEP,
        TR_WRAP,
        TR_LOAD,
        TR_ILLEGAL
    } trans_e;

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier for one observed counter transition.
// Compares the freshly sampled count against the previous sample.
module count_step_classifier
    import count_pkg::*;
#(
    parameter int WIDTH     = COUNT_WIDTH,
    parameter int MAX_COUNT = COUNT_MAX
) (
    input  logic [WIDTH-1:0] cnt_q_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic             ud_q_i,
    input  logic             ld_q_i,
    output trans_e           cls_o
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

    logic in_range;
    logic up_step;
    logic dn_step;
    logic up_wrap;
    logic dn_wrap;

    always_comb begin
        // Either side outside 0..MAX_COUNT can never be a legal count move
        in_range = (int'(cnt_q_i) <= MAX_COUNT) && (int'(count_i) <= MAX_COUNT);
        up_step  = (cnt_q_i < MAXV) && (count_i == cnt_q_i + WIDTH'(1));
        dn_step  = (cnt_q_i != '0) && (count_i == cnt_q_i - WIDTH'(1));
        up_wrap  = (cnt_q_i == MAXV) && (count_i == '0);
        dn_wrap  = (cnt_q_i == '0) && (count_i == MAXV);

        cls_o = TR_ILLEGAL;
        if (ld_q_i) begin
            cls_o = TR_LOAD;
        end else if (!in_range) begin
            cls_o = TR_ILLEGAL;
        end else if (count_i == cnt_q_i) begin
            cls_o = TR_HOLD;
        end else if (ud_q_i ? up_step : dn_step) begin
            cls_o = TR_STEP;
        end else if (ud_q_i ? up_wrap : dn_wrap) begin
            cls_o = TR_WRAP;
        end
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// Watches the up/down counter, pulses carry/borrow on wrap and flags
// illegal jumps; a load resynchronises tracking after a fault.
module count_wrap_monitor
    import count_pkg::*;
#(
    parameter int WIDTH     = COUNT_WIDTH,
    parameter int MAX_COUNT = COUNT_MAX,
    parameter int HI_WIDTH  = 4,
    parameter int ERR_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [WIDTH-1:0]          count,
    input  logic                      up_down,
    input  logic                      load,
    output logic                      carry,
    output logic                      borrow,
    output logic                      err,
    output logic                      fault,
    output logic                      ext_valid,
    output logic [HI_WIDTH+WIDTH-1:0] ext_count,
    output logic [ERR_WIDTH-1:0]      err_cnt
);

    mon_state_e           state_q, state_d;
    logic [WIDTH-1:0]     cnt_q;
    logic                 ld_q;
    logic                 ud_q;
    logic [HI_WIDTH-1:0]  hi_q, hi_d;
    logic [ERR_WIDTH-1:0] ecnt_q, ecnt_d;
    logic                 carry_q, carry_d;
    logic                 borrow_q, borrow_d;
    logic                 err_q, err_d;
    logic                 fault_q;
    logic                 valid_q;
    trans_e               cls;

    count_step_classifier #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_cls (
        .cnt_q_i (cnt_q),
        .count_i (count),
        .ud_q_i  (ud_q),
        .ld_q_i  (ld_q),
        .cls_o   (cls)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        ecnt_d   = ecnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_INIT: state_d = ST_TRACK;
            ST_TRACK: begin
                case (cls)
                    TR_LOAD: hi_d = '0;
                    TR_WRAP: begin
                        carry_d  = ud_q;
                        borrow_d = !ud_q;
                        hi_d     = ud_q ? hi_q + HI_WIDTH'(1)
                                        : hi_q - HI_WIDTH'(1);
                    end
                    TR_ILLEGAL: begin
                        err_d   = 1'b1;
                        ecnt_d  = (ecnt_q == '1) ? ecnt_q
                                                 : ecnt_q + ERR_WIDTH'(1);
                        state_d = ST_FAULT;
                    end
                    default: ;
                endcase
            end
            ST_FAULT: begin
                if (ld_q) begin
                    state_d = ST_TRACK;
                    hi_d    = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            ld_q     <= 1'b0;
            ud_q     <= 1'b0;
            hi_q     <= '0;
            ecnt_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            err_q    <= 1'b0;
            fault_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= count;
            ld_q     <= load;
            ud_q     <= up_down;
            hi_q     <= hi_d;
            ecnt_q   <= ecnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            err_q    <= err_d;
            fault_q  <= (state_d == ST_FAULT);
            valid_q  <= (state_d == ST_TRACK);
        end
    end

    assign carry     = carry_q;
    assign borrow    = borrow_q;
    assign err       = err_q;
    assign fault     = fault_q;
    assign ext_valid = valid_q;
    assign ext_count = {hi_q, cnt_q};
    assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: directed scenarios plus random traffic on
// two instances (MAX_COUNT 15 and 9), checked against a behavioural model.
module tb_count_wrap_monitor;
    import count_pkg::*;

    localparam int S_INIT  = 0;
    localparam int S_TRACK = 1;
    localparam int S_FAULT = 2;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cnt_i [2];
    logic       ud_i  [2];
    logic       ld_i  [2];
    logic       carry_o  [2];
    logic       borrow_o [2];
    logic       err_o    [2];
    logic       fault_o  [2];
    logic       valid_o  [2];
    logic [7:0] ext_o    [2];
    logic [7:0] ecnt_o   [2];

    int checks = 0;
    int errors = 0;

    int m_st   [2];
    int m_prev [2];
    int m_pld  [2];
    int m_pud  [2];
    int m_hi   [2];
    int m_ecnt [2];
    int e_car  [2];
    int e_bor  [2];
    int e_err  [2];

    always #5 clock = ~clock;

    count_wrap_monitor #(
        .WIDTH(4), .MAX_COUNT(15), .HI_WIDTH(4), .ERR_WIDTH(8)
    ) dut0 (
        .clock(clock), .resetn(rst_n), .count(cnt_i[0]),
        .up_down(ud_i[0]), .load(ld_i[0]), .carry(carry_o[0]),
        .borrow(borrow_o[0]), .err(err_o[0]), .fault(fault_o[0]),
        .ext_valid(valid_o[0]), .ext_count(ext_o[0]), .err_cnt(ecnt_o[0])
    );

    count_wrap_monitor #(
        .WIDTH(4), .MAX_COUNT(9), .HI_WIDTH(4), .ERR_WIDTH(8)
    ) dut1 (
        .clock(clock), .resetn(rst_n), .count(cnt_i[1]),
        .up_down(ud_i[1]), .load(ld_i[1]), .carry(carry_o[1]),
        .borrow(borrow_o[1]), .err(err_o[1]), .fault(fault_o[1]),
        .ext_valid(valid_o[1]), .ext_count(ext_o[1]), .err_cnt(ecnt_o[1])
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: classify the move by modular arithmetic on 0..mx
    task automatic model_edge(int k);
        int mx = (k == 0) ? 15 : 9;
        int c  = int'(cnt_i[k]);
        trans_e tc;
        e_car[k] = 0;
        e_bor[k] = 0;
        e_err[k] = 0;
        if (!rst_n) begin
            m_st[k] = S_INIT;
            m_prev[k] = 0;
            m_pld[k] = 0;
            m_pud[k] = 0;
            m_hi[k] = 0;
            m_ecnt[k] = 0;
            return;
        end
        if (m_pld[k] != 0) tc = TR_LOAD;
        else if (c > mx || m_prev[k] > mx) tc = TR_ILLEGAL;
        else if (c == m_prev[k]) tc = TR_HOLD;
        else if (m_pud[k] != 0 && c == (m_prev[k] + 1) % (mx + 1))
            tc = (c == 0) ? TR_WRAP : TR_STEP;
        else if (m_pud[k] == 0 && c == (m_prev[k] + mx) % (mx + 1))
            tc = (c == mx) ? TR_WRAP : TR_STEP;
        else tc = TR_ILLEGAL;

        if (m_st[k] == S_INIT) begin
            m_st[k] = S_TRACK;
        end else if (m_st[k] == S_TRACK) begin
            if (tc == TR_LOAD) m_hi[k] = 0;
            if (tc == TR_WRAP && m_pud[k] != 0) begin
                e_car[k] = 1;
                m_hi[k] = (m_hi[k] + 1) % 16;
            end
            if (tc == TR_WRAP && m_pud[k] == 0) begin
                e_bor[k] = 1;
                m_hi[k] = (m_hi[k] + 15) % 16;
            end
            if (tc == TR_ILLEGAL) begin
                e_err[k] = 1;
                m_ecnt[k] = (m_ecnt[k] < 255) ? m_ecnt[k] + 1 : 255;
                m_st[k] = S_FAULT;
            end
        end else if (m_pld[k] != 0) begin
            m_st[k] = S_TRACK;
            m_hi[k] = 0;
        end
        m_prev[k] = c;
        m_pld[k] = int'(ld_i[k]);
        m_pud[k] = int'(ud_i[k]);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("carry%0d", k), carry_o[k], e_car[k]);
            check($sformatf("borrow%0d", k), borrow_o[k], e_bor[k]);
            check($sformatf("err%0d", k), err_o[k], e_err[k]);
            check($sformatf("fault%0d", k), fault_o[k], m_st[k] == S_FAULT);
            check($sformatf("valid%0d", k), valid_o[k], m_st[k] == S_TRACK);
            check($sformatf("ext%0d", k), ext_o[k],
                  (m_hi[k] * 16) + m_prev[k]);
            check($sformatf("ecnt%0d", k), ecnt_o[k], m_ecnt[k]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic step0(int c, bit ud, bit ld);
        cnt_i[0] = 4'(c);
        ud_i[0] = ud;
        ld_i[0] = ld;
        step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cnt_i[k] = 4'd0;
            ud_i[k] = 1'b1;
            ld_i[k] = 1'b0;
        end
        // Up wrap with carry
        rst_n = 1'b0;
        step0(13, 1, 0);
        check("rst_valid", valid_o[0], 0);
        check("rst_ext", ext_o[0], 8'h00);
        rst_n = 1'b1;
        step0(13, 1, 0);
        step0(14, 1, 0);
        step0(15, 1, 0);
        step0(0, 1, 0);
        check("t1_carry", carry_o[0], 1);
        check("t1_ext10", ext_o[0], 8'h10);
        step0(1, 1, 0);
        check("t1_ext11", ext_o[0], 8'h11);
        // Down wrap with borrow
        step0(1, 0, 0);
        step0(0, 0, 0);
        check("t2_ext10", ext_o[0], 8'h10);
        step0(15, 0, 0);
        check("t2_borrow", borrow_o[0], 1);
        check("t2_ext0f", ext_o[0], 8'h0F);
        step0(14, 0, 0);
        check("t2_ext0e", ext_o[0], 8'h0E);
        // Load clears wrap_hi
        step0(14, 1, 0);
        step0(15, 1, 0);
        for (int v = 0; v < 16; v++) step0(v, 1, 0);
        for (int v = 0; v < 6; v++) step0(v, 1, 0);
        check("t3_hi2", ext_o[0], 8'h25);
        step0(5, 1, 1);
        step0(9, 1, 0);
        check("t3_noerr", err_o[0], 0);
        check("t3_ext09", ext_o[0], 8'h09);
        check("t3_valid", valid_o[0], 1);
        // Illegal jump, fault, resync by load
        step0(9, 1, 1);
        step0(3, 1, 0);
        step0(3, 1, 0);
        step0(7, 1, 0);
        check("t4_err", err_o[0], 1);
        check("t4_fault", fault_o[0], 1);
        check("t4_ecnt", ecnt_o[0], 1);
        step0(8, 1, 0);
        step0(15, 1, 0);
        step0(0, 1, 0);
        check("t4_nocarry", carry_o[0], 0);
        step0(0, 1, 1);
        step0(4, 1, 0);
        check("t4_valid", valid_o[0], 1);
        check("t4_ext04", ext_o[0], 8'h04);
        // Mid-run reset
        for (int i = 0; i < 45; i++) step0((5 + i) % 16, 1, 0);
        check("t5_hi3", ext_o[0][7:4], 3);
        rst_n = 1'b0;
        step0(3, 1, 0);
        check("t5_rst_ext", ext_o[0], 0);
        check("t5_rst_valid", valid_o[0], 0);
        rst_n = 1'b1;
        step0(3, 1, 0);
        check("t5_valid_up", valid_o[0], 1);
        // MAX_COUNT=9 wrap of wrap_hi and error saturation
        cnt_i[1] = 4'd0;
        step();
        for (int i = 1; i < 160; i++) begin
            cnt_i[1] = 4'(i % 10);
            step();
        end
        check("t6_hi15", ext_o[1], 8'hF9);
        cnt_i[1] = 4'd0;
        step();
        check("t6_carry", carry_o[1], 1);
        check("t6_hiwrap", ext_o[1], 8'h00);
        for (int v = 1; v < 10; v++) begin
            cnt_i[1] = 4'(v);
            step();
        end
        cnt_i[1] = 4'd12;
        step();
        check("t6_err12", err_o[1], 1);
        for (int i = 0; i < 300; i++) begin
            cnt_i[1] = 4'd0;
            ld_i[1] = 1'b1;
            step();
            ld_i[1] = 1'b0;
            step();
            cnt_i[1] = 4'd5;
            step();
        end
        check("t6_sat", ecnt_o[1], 255);
        // Random traffic on both instances
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            for (int k = 0; k < 2; k++) begin
                int mx = (k == 0) ? 15 : 9;
                int c = int'(cnt_i[k]);
                int r = $urandom_range(0, 9);
                if (c > mx) c = 0;
                if (r < 3) cnt_i[k] = 4'(c);
                else if (r < 6) cnt_i[k] = 4'((c + 1) % (mx + 1));
                else if (r < 9) cnt_i[k] = 4'((c + mx) % (mx + 1));
                else cnt_i[k] = 4'($urandom_range(0, 15));
                ud_i[k] = 1'($urandom_range(0, 1));
                ld_i[k] = ($urandom_range(0, 7) == 0);
            end
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
